// File: rtl/ka750_usc_seq.sv
// Microsequencer: holds the micro-PC, resolves the next control store address from
// NEXT/BUT/JSR/RETURN/dispatch/trap, and keeps a circular subroutine return stack.
module ka750_usc_seq #(
   parameter int              AW        = 14,
   parameter int              STK_DEPTH = 8,
   parameter logic [AW-1:0]   RESET_VEC = 14'h0000,
   parameter logic [AW-1:0]   TRAP_VEC  = 14'h0010
) (
   input  logic          m_clk_h,
   input  logic          reset_l,
   input  logic          m_clk_enable_h,
   input  logic [5:0]    cs_next_h,
   input  logic          cs_jsr_h,
   input  logic [5:0]    cs_but_h,
   input  logic [15:0]   cond_h,
   input  logic [AW-1:0] dispatch_addr_h,
   input  logic          trap_req_h,
   output logic [AW-1:0] cs_addr_h,
   output logic [4:0]    stk_depth_h,
   output logic          stk_err_h,
   output logic          trap_ack_h
);

   localparam int         PW   = $clog2(STK_DEPTH);
   localparam logic [4:0] FULL = 5'(STK_DEPTH);

   logic [AW-1:0] upc_q, upc_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [4:0]    depth_q, depth_d;
   logic          err_q, err_d;
   logic          ack_q, ack_d;
   logic [AW-1:0] stk_q [STK_DEPTH];
   logic [AW-1:0] stk_d [STK_DEPTH];

   logic [AW-1:0] nb;
   logic [AW-1:0] nxt;
   logic [AW-1:0] top;
   logic [AW-1:0] push_val;
   logic [PW-1:0] ptr_m1;
   logic [PW-1:0] ptr_w;
   logic [4:0]    depth_w;
   logic [3:0]    pidx;
   logic [1:0]    pair;
   logic          is_ret;
   logic          empty;
   logic          push_en;

   always_comb begin
      nb     = {upc_q[AW-1:6], cs_next_h};
      ptr_m1 = ptr_q - PW'(1);
      top    = stk_q[ptr_m1];
      is_ret = (cs_but_h == 6'h3F);
      empty  = (depth_q == 5'd0);
      pidx   = {cs_but_h[2:0], 1'b0};
      pair   = {cond_h[pidx + 4'd1], cond_h[pidx]};
      case (cs_but_h[5:4])
         2'b00:   nxt = nb;
         2'b01:   nxt = nb | {{(AW-1){1'b0}}, cond_h[cs_but_h[3:0]]};
         2'b10:   nxt = nb | {{(AW-2){1'b0}}, pair};
         default: nxt = is_ret ? (empty ? RESET_VEC : top) : dispatch_addr_h;
      endcase
   end

   always_comb begin
      upc_d    = upc_q;
      ptr_d    = ptr_q;
      depth_d  = depth_q;
      err_d    = err_q;
      ack_d    = 1'b0;
      stk_d    = stk_q;
      ptr_w    = ptr_q;
      depth_w  = depth_q;
      push_en  = 1'b0;
      push_val = nxt;
      if (m_clk_enable_h) begin
         if (trap_req_h) begin
            // Trap saves where the microword was heading; its own JSR/RETURN are dropped.
            upc_d    = TRAP_VEC;
            ack_d    = 1'b1;
            push_en  = 1'b1;
            push_val = nxt;
         end else begin
            upc_d = nxt;
            if (is_ret) begin
               if (empty) begin
                  err_d = 1'b1;
               end else begin
                  ptr_w   = ptr_m1;
                  depth_w = depth_q - 5'd1;
               end
            end
            push_en  = cs_jsr_h;
            push_val = upc_q + {{(AW-1){1'b0}}, 1'b1};
         end
         ptr_d   = ptr_w;
         depth_d = depth_w;
         // A push at full lands on the oldest slot, since the write pointer wraps onto it.
         if (push_en) begin
            stk_d[ptr_w] = push_val;
            ptr_d        = ptr_w + PW'(1);
            if (depth_w == FULL) begin
               err_d = 1'b1;
            end else begin
               depth_d = depth_w + 5'd1;
            end
         end
      end
   end

   always_ff @(posedge m_clk_h or negedge reset_l) begin
      if (!reset_l) begin
         upc_q   <= RESET_VEC;
         ptr_q   <= '0;
         depth_q <= 5'd0;
         err_q   <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         upc_q   <= upc_d;
         ptr_q   <= ptr_d;
         depth_q <= depth_d;
         err_q   <= err_d;
         ack_q   <= ack_d;
      end
   end

   always_ff @(posedge m_clk_h) begin
      stk_q <= stk_d;
   end

   assign cs_addr_h   = upc_q;
   assign stk_depth_h = depth_q;
   assign stk_err_h   = err_q;
   assign trap_ack_h  = ack_q;

endmodule

// File: tb/tb_ka750_usc_seq.sv
// Bench for ka750_usc_seq: directed vector table, stack-limit and reset sequences,
// then random microwords checked against a queue-based sequencer model.
module tb_ka750_usc_seq;

   localparam int AW   = 14;
   localparam int MASK = 'h3FFF;
   localparam int RVEC = 'h0000;
   localparam int TVEC = 'h0010;
   localparam int SDEP = 8;

   logic          m_clk_h;
   logic          reset_l;
   logic          m_clk_enable_h;
   logic [5:0]    cs_next_h;
   logic          cs_jsr_h;
   logic [5:0]    cs_but_h;
   logic [15:0]   cond_h;
   logic [AW-1:0] dispatch_addr_h;
   logic          trap_req_h;
   logic [AW-1:0] cs_addr_h;
   logic [4:0]    stk_depth_h;
   logic          stk_err_h;
   logic          trap_ack_h;

   ka750_usc_seq dut (
      .m_clk_h         (m_clk_h),
      .reset_l         (reset_l),
      .m_clk_enable_h  (m_clk_enable_h),
      .cs_next_h       (cs_next_h),
      .cs_jsr_h        (cs_jsr_h),
      .cs_but_h        (cs_but_h),
      .cond_h          (cond_h),
      .dispatch_addr_h (dispatch_addr_h),
      .trap_req_h      (trap_req_h),
      .cs_addr_h       (cs_addr_h),
      .stk_depth_h     (stk_depth_h),
      .stk_err_h       (stk_err_h),
      .trap_ack_h      (trap_ack_h)
   );

   initial begin
      m_clk_h = 1'b0;
      forever #5 m_clk_h = ~m_clk_h;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the return stack is a queue with the newest entry at the back.
   int m_upc;
   int m_stk[$];
   bit m_err;
   bit m_ack;

   function automatic void model_reset();
      m_upc = RVEC;
      m_stk.delete();
      m_err = 1'b0;
      m_ack = 1'b0;
   endfunction

   function automatic void model_push(input int v);
      if (m_stk.size() == SDEP) begin
         void'(m_stk.pop_front());
         m_err = 1'b1;
      end
      m_stk.push_back(v);
   endfunction

   function automatic void model_edge(input bit en, input int nxt, input bit jsr, input int but,
                                      input logic [15:0] cond, input int disp, input bit trap);
      int nb;
      int tgt;
      int tos;
      bit ret;
      if (!en) begin
         m_ack = 1'b0;
         return;
      end
      nb  = (m_upc & 'h3FC0) | nxt;
      ret = (but == 63);
      tos = (m_stk.size() == 0) ? RVEC : m_stk[m_stk.size() - 1];
      case (but / 16)
         0:       tgt = nb;
         1:       tgt = nb | int'(cond[but % 16]);
         2:       tgt = nb | ((int'(cond) >> (2 * (but % 8))) % 4);
         default: tgt = ret ? tos : disp;
      endcase
      if (trap) begin
         model_push(tgt);
         m_upc = TVEC;
         m_ack = 1'b1;
      end else begin
         m_ack = 1'b0;
         if (ret) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else void'(m_stk.pop_back());
         end
         if (jsr) model_push((m_upc + 1) & MASK);
         m_upc = tgt;
      end
   endfunction

   task automatic cmp_model(input string tag);
      chk({tag, ".addr"},  int'(cs_addr_h),   m_upc);
      chk({tag, ".depth"}, int'(stk_depth_h), m_stk.size());
      chk({tag, ".err"},   int'(stk_err_h),   int'(m_err));
      chk({tag, ".ack"},   int'(trap_ack_h),  int'(m_ack));
   endtask

   task automatic step(input bit en, input int nxt, input bit jsr, input int but,
                       input logic [15:0] cond, input int disp, input bit trap, input string tag);
      m_clk_enable_h  = en;
      cs_next_h       = 6'(nxt);
      cs_jsr_h        = jsr;
      cs_but_h        = 6'(but);
      cond_h          = cond;
      dispatch_addr_h = AW'(disp);
      trap_req_h      = trap;
      model_edge(en, nxt, jsr, but, cond, disp, trap);
      @(posedge m_clk_h);
      #1;
      cmp_model(tag);
   endtask

   typedef struct {
      bit          en;
      int          nxt;
      bit          jsr;
      int          but;
      logic [15:0] cond;
      int          disp;
      bit          trap;
      int          e_addr;
      int          e_depth;
      bit          e_ack;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input bit en, input int nxt, input bit jsr, input int but,
                               input logic [15:0] cond, input int disp, input bit trap,
                               input int e_addr, input int e_depth, input bit e_ack);
      vec_t v;
      v.en = en; v.nxt = nxt; v.jsr = jsr; v.but = but; v.cond = cond; v.disp = disp;
      v.trap = trap; v.e_addr = e_addr; v.e_depth = e_depth; v.e_ack = e_ack;
      return v;
   endfunction

   initial begin
      m_clk_enable_h  = 1'b0;
      cs_next_h       = '0;
      cs_jsr_h        = 1'b0;
      cs_but_h        = '0;
      cond_h          = '0;
      dispatch_addr_h = '0;
      trap_req_h      = 1'b0;
      reset_l         = 1'b0;
      model_reset();

      //          en nxt  jsr but   cond     disp     trap  addr     dep ack
      tbl.push_back(mk(1, 0,    0, 'h30, 16'h0, 'h0040, 0, 'h0040, 0, 0));
      tbl.push_back(mk(1, 'h05, 0, 'h00, 16'h0, 0,      0, 'h0045, 0, 0));
      tbl.push_back(mk(0, 'h3F, 0, 'h30, 16'h0, 'h1ABC, 0, 'h0045, 0, 0));
      tbl.push_back(mk(0, 'h3F, 0, 'h30, 16'h0, 'h1ABC, 0, 'h0045, 0, 0));
      tbl.push_back(mk(0, 'h3F, 0, 'h30, 16'h0, 'h1ABC, 0, 'h0045, 0, 0));
      tbl.push_back(mk(1, 0,    0, 'h30, 16'h0, 'h0100, 0, 'h0100, 0, 0));
      tbl.push_back(mk(1, 'h08, 0, 'h13, 16'h0008, 0,   0, 'h0109, 0, 0));
      tbl.push_back(mk(1, 0,    0, 'h30, 16'h0, 'h0100, 0, 'h0100, 0, 0));
      tbl.push_back(mk(1, 'h08, 0, 'h13, 16'hFFF7, 0,   0, 'h0108, 0, 0));
      tbl.push_back(mk(1, 0,    0, 'h30, 16'h0, 'h0100, 0, 'h0100, 0, 0));
      tbl.push_back(mk(1, 'h08, 0, 'h22, 16'h0030, 0,   0, 'h010B, 0, 0));
      tbl.push_back(mk(1, 0,    0, 'h30, 16'h0, 'h0200, 0, 'h0200, 0, 0));
      tbl.push_back(mk(1, 'h30, 1, 'h00, 16'h0, 0,      0, 'h0230, 1, 0));
      tbl.push_back(mk(1, 0,    0, 'h3F, 16'h0, 0,      0, 'h0201, 0, 0));
      tbl.push_back(mk(1, 0,    0, 'h30, 16'h0, 'h0200, 0, 'h0200, 0, 0));
      tbl.push_back(mk(1, 0,    1, 'h30, 16'h0, 'h0300, 0, 'h0300, 1, 0));
      tbl.push_back(mk(1, 0,    1, 'h3F, 16'h0, 0,      0, 'h0201, 1, 0));
      tbl.push_back(mk(1, 0,    0, 'h3F, 16'h0, 0,      0, 'h0301, 0, 0));
      tbl.push_back(mk(1, 0,    0, 'h30, 16'h0, 'h1ABC, 0, 'h1ABC, 0, 0));
      tbl.push_back(mk(1, 0,    1, 'h30, 16'h0, 'h0045, 1, 'h0010, 1, 1));
      tbl.push_back(mk(1, 0,    0, 'h3F, 16'h0, 0,      0, 'h0045, 0, 0));
      tbl.push_back(mk(0, 'h05, 0, 'h00, 16'h0, 0,      1, 'h0045, 0, 0));
      tbl.push_back(mk(0, 'h05, 0, 'h00, 16'h0, 0,      1, 'h0045, 0, 0));
      tbl.push_back(mk(1, 'h05, 0, 'h00, 16'h0, 0,      1, 'h0010, 1, 1));
      tbl.push_back(mk(1, 0,    0, 'h3F, 16'h0, 0,      0, 'h0045, 0, 0));

      #1;
      chk("rst.addr",  int'(cs_addr_h),   RVEC);
      chk("rst.depth", int'(stk_depth_h), 0);
      chk("rst.err",   int'(stk_err_h),   0);
      chk("rst.ack",   int'(trap_ack_h),  0);
      @(posedge m_clk_h);
      #1;
      chk("rst_edge.addr", int'(cs_addr_h), RVEC);
      #2;
      reset_l = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].en, tbl[i].nxt, tbl[i].jsr, tbl[i].but, tbl[i].cond, tbl[i].disp,
              tbl[i].trap, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d.exp_addr", i),  int'(cs_addr_h),   tbl[i].e_addr);
         chk($sformatf("vec%0d.exp_depth", i), int'(stk_depth_h), tbl[i].e_depth);
         chk($sformatf("vec%0d.exp_ack", i),   int'(trap_ack_h),  int'(tbl[i].e_ack));
         chk($sformatf("vec%0d.exp_err", i),   int'(stk_err_h),   0);
      end

      // Stack limits: nine calls overflow an eight-deep stack, nine returns underflow it.
      for (int i = 0; i < 9; i++) begin
         step(1, i, 1, 'h00, 16'h0, 0, 0, $sformatf("jsr%0d", i));
         if (i == 7) chk("jsr8.err_clear", int'(stk_err_h), 0);
      end
      chk("ovf.depth", int'(stk_depth_h), 8);
      chk("ovf.err",   int'(stk_err_h),   1);
      for (int i = 0; i < 8; i++) step(1, 0, 0, 'h3F, 16'h0, 0, 0, $sformatf("ret%0d", i));
      chk("pop8.depth", int'(stk_depth_h), 0);
      step(1, 0, 0, 'h3F, 16'h0, 'h1234, 0, "ret_empty");
      chk("unf.addr",  int'(cs_addr_h),   RVEC);
      chk("unf.depth", int'(stk_depth_h), 0);
      chk("unf.err",   int'(stk_err_h),   1);

      // Async reset in the middle of a stalled trap request clears the sticky error at once.
      step(1, 'h22, 0, 'h30, 16'h0, 'h0777, 0, "pre_rst");
      m_clk_enable_h = 1'b0;
      trap_req_h     = 1'b1;
      #2;
      reset_l = 1'b0;
      #1;
      model_reset();
      chk("midrst.addr", int'(cs_addr_h), RVEC);
      chk("midrst.err",  int'(stk_err_h), 0);
      m_clk_enable_h = 1'b1;
      @(posedge m_clk_h);
      #1;
      cmp_model("midrst_edge");
      #2;
      reset_l = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         int sel;
         int but;
         sel = int'($urandom_range(0, 7));
         case (sel)
            0, 1:    but = int'($urandom_range(0, 15));
            2:       but = 'h10 + int'($urandom_range(0, 15));
            3:       but = 'h20 + int'($urandom_range(0, 15));
            4, 5:    but = 'h3F;
            6:       but = 'h30 + int'($urandom_range(0, 14));
            default: but = int'($urandom_range(0, 63));
         endcase
         step(($urandom_range(0, 4) != 0), int'($urandom_range(0, 63)),
              ($urandom_range(0, 2) == 0), but, 16'($urandom),
              int'($urandom_range(0, MASK)), ($urandom_range(0, 9) == 0),
              $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ka750_usc_seq.md
Name: ka750_usc_seq

Overview:
- Microsequencer stage directly upstream of the data path module.
- Holds the micro-PC (uPC) and drives the control store address. The control store returns the cs_* microword to the datapath and back to this block.
- Computes the next address from the NEXT field, the BUT microtest select, JSR, subroutine return, dispatch and trap.
- Advances only on enabled M clock edges, so memory stalls freeze it in step with the datapath micro-op buffers.

Parameters:
- AW, 14, control store address width (≥8).
- STK_DEPTH, 8, subroutine return stack entries (power of 2, 2..16).
- RESET_VEC, 14'h0000, uPC value after reset.
- TRAP_VEC, 14'h0010, microtrap entry address.

Ports:
- m_clk_h  in  1  sequencer clock; all state updates on rising edge.
- reset_l  in  1  asynchronous active-low reset.
- m_clk_enable_h  in  1  M clock enable (low during a memory stall); state changes only when high.
- cs_next_h  in  6  NEXT field of the current microword.
- cs_jsr_h  in  1  JSR bit of the current microword.
- cs_but_h  in  6  BUT microtest select of the current microword.
- cond_h  in  16  branch condition inputs (flags, wmuxz, status).
- dispatch_addr_h  in  AW  IRD/dispatch target address.
- trap_req_h  in  1  microtrap request.
- cs_addr_h  out  AW  control store address, equal to the uPC register.
- stk_depth_h  out  5  current number of valid stack entries.
- stk_err_h  out  1  sticky stack overflow/underflow error.
- trap_ack_h  out  1  one-cycle pulse on the enabled edge that takes a trap.

Behaviour:
- Reset (async, reset_l=0) sets:
  - uPC=RESET_VEC;
  - stack pointer 0 and stk_depth_h=0;
  - stk_err_h=0 and trap_ack_h=0.
  - Stack RAM contents are don't-care.
- Stall: when m_clk_enable_h=0 on an edge, all registers hold and trap_ack_h=0. A trap request during a stall is not lost; it is taken on the first enabled edge while still asserted. The requester holds trap_req_h until trap_ack_h.
- Base next address: nb = {uPC[AW-1:6], cs_next_h}. The page is kept from the current uPC.
- BUT decode (field value b):
  - b[5:4]=00: next = nb.
  - b[5:4]=01: next = nb | cond_h[b[3:0]] in bit 0.
  - b[5:4]=10: next = nb | {cond_h[2*b[2:0]+1], cond_h[2*b[2:0]]} in bits [1:0]. b[3] is reserved and ignored.
  - b=6'h3F: RETURN; next = top of stack; pop.
  - Other 11xxxx values: DISPATCH; next = dispatch_addr_h.
- JSR: when cs_jsr_h=1, push ret = uPC+1 (mod 2^AW). next is still computed by BUT.
- JSR together with RETURN: pop and push in the same cycle. The top entry is replaced by uPC+1, depth is unchanged, and next = the old top.
- Stack:
  - Circular, STK_DEPTH entries.
  - Push at full: the oldest entry is overwritten, depth stays STK_DEPTH, stk_err_h←1.
  - Pop at empty: next = RESET_VEC, depth stays 0, stk_err_h←1.
  - stk_err_h is cleared only by reset.
- Trap has highest priority on an enabled edge with trap_req_h=1:
  - The microword's computed next address (after BUT) is pushed, with normal full-stack rules.
  - uPC←TRAP_VEC and trap_ack_h=1 for that edge only.
  - The microword's own JSR push and RETURN pop are suppressed.
- Latency: uPC updates on the enabled edge after the microword is presented. cs_addr_h is registered, with no combinational path from inputs.
- Arithmetic: all address sums wrap modulo 2^AW. Page bits are never altered by BUT OR-ing.
- Reset asserted mid-stall or mid-trap takes effect immediately. Deassertion needs no synchronous recovery beyond the next edge.

Test Plan:
- Reset/sequential: reset_l pulse, then NEXT=0x05, BUT=0 with uPC page 0x0040 → cs_addr_h=0x0000 during reset, 0x0045 after one enabled edge. With m_clk_enable_h=0 for 3 edges, it holds 0x0045.
- Microbranch: uPC=0x0100, NEXT=0x08, BUT=6'h13 (bit-3 test), cond_h[3]=1 → 0x0109; with cond_h[3]=0 → 0x0108. BUT=6'h22, cond_h[5:4]=2'b11 → 0x010B.
- Subroutine: at uPC=0x0200 JSR with NEXT=0x30 → 0x0230, depth=1. At 0x0230 BUT=6'h3F → 0x0201, depth=0. JSR+RETURN at 0x0300 with top=0x0201 → next 0x0201, top becomes 0x0301.
- Stack limits: 9 consecutive JSRs (STK_DEPTH=8) → depth=8 and stk_err_h=1 after the 9th. After 8 returns depth=0; a 9th return → uPC=RESET_VEC, stk_err_h stays 1.
- Dispatch/trap: BUT=6'h30 with dispatch_addr_h=0x1ABC → 0x1ABC. trap_req_h=1 with computed next 0x0045 → uPC=0x0010, trap_ack_h pulses one cycle, top=0x0045. A later RETURN → 0x0045.
- Trap during stall: trap_req_h held with m_clk_enable_h=0 for 2 edges → no ack, uPC unchanged. The first enabled edge → uPC=0x0010 and trap_ack_h=1.
